elevator_car_drive: RTL and testbench
=====================================

# elevator_car_drive

Car-side responder for the elevator floor-command interface: it accepts a target-floor command from the elevator controller, models car travel with a per-floor travel timer, reports floor position, and runs the door open/dwell cycle. It is the counterpart of the controller's request/command logic. It is used as the car model in system benches and as the motion sequencer on the FPGA board. It serves three floors: ground = 0, first = 1, second = 2.

## Interface
- TRAVEL_CYCLES, default 50_000_000: clock cycles to move one floor; legal range 1..2^26.
- DOOR_CYCLES, default 100_000_000: clock cycles the door stays open on arrival; legal range 1..2^27.
- clk  input  1  single system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserts immediately when low, deasserts synchronously to clk).
- cmd_valid  input  1  controller presents a target floor.
- cmd_floor  input  2  target floor code: 0, 1, 2; 3 is illegal.
- cmd_ready  output  1  car idle, command accepted on the clock edge where cmd_valid && cmd_ready.
- cur_floor  output  2  current car floor.
- floor_led  output  3  one-hot copy of cur_floor (bit n = floor n).
- moving  output  1  car between floors.
- dir_up  output  1  travel direction while moving (1 = up); holds its last value otherwise.
- arrive  output  1  one-cycle pulse on reaching the target floor.
- door_open  output  1  door open.
- fault  output  1  sticky illegal-command flag (see Configuration).

## Operation
- States:
  - IDLE: cmd_ready=1.
  - MOVE: moving=1.
  - DOOR: door_open=1.
- All outputs are registered.
- IDLE, accept with target ≠ cur_floor:
  - Latch target, set dir_up = (target > cur_floor).
  - Load travel counter with TRAVEL_CYCLES-1, go to MOVE.
- IDLE, accept with target == cur_floor:
  - Go directly to DOOR, pulse arrive, load door counter with DOOR_CYCLES-1.
  - moving stays 0.
- MOVE:
  - Counter ≠ 0: decrement.
  - Counter == 0: cur_floor steps ±1.
  - If the new floor equals target: pulse arrive, load door counter, go to DOOR.
  - Otherwise reload the travel counter and stay in MOVE.
  - arrive fires only at the target floor, never at intermediate floors.
- DOOR:
  - Counter ≠ 0: decrement.
  - Counter == 0: go to IDLE, door_open=0.
- cmd_valid while not IDLE is ignored; it is not queued, and the controller must hold it until cmd_ready.
- cmd_floor is sampled only on the accept edge; changes during MOVE/DOOR have no effect.
- Counter width: $clog2 of the larger parameter plus one bit. No wrap-around is possible in legal configurations.
- Reset values:
  - Internal: state IDLE, counters 0, target 0.
  - Outputs: cmd_ready=1, cur_floor=0, floor_led=3'b001, moving=0, dir_up=0, arrive=0, door_open=0, fault=0.

## Timing
- Accept at edge E:
  - cmd_ready low and moving high after E.
  - First floor step at edge E+TRAVEL_CYCLES.
  - Each further step TRAVEL_CYCLES later.
- Arrival edge A: cur_floor, floor_led and arrive update together at A. arrive is high for exactly the cycle after A.
- door_open is high for exactly DOOR_CYCLES cycles starting after A. cmd_ready returns high after edge A+DOOR_CYCLES.
- Back-to-back commands: the earliest next accept is the edge where cmd_ready is first sampled high. There are no dead cycles beyond that.
- Same-floor command accepted at E: arrive after E; door_open for DOOR_CYCLES cycles; cmd_ready high after E+DOOR_CYCLES.
- Reset asserted mid-MOVE or mid-DOOR: all outputs go to their reset values immediately, without waiting for a clock edge. The in-flight command is discarded and cur_floor returns to 0.

## Configuration
- ELEV_CMD_CHECK_EN defined:
  - cmd_floor==3 in IDLE with cmd_valid is accepted (one-cycle handshake) and discarded.
  - fault sets and stays set until reset; the car stays in IDLE with outputs unchanged.
  - Later legal commands are still serviced.
- ELEV_CMD_CHECK_EN undefined:
  - A floor-3 command is accepted and discarded with no other effect.
  - fault is tied to 0.

## Test plan
All scenarios use TRAVEL_CYCLES=4, DOOR_CYCLES=3.
- Reset release: cur_floor=0, floor_led=001, cmd_ready=1, moving=0, door_open=0, arrive=0, fault=0.
- Floor 1 accepted at edge 0: cmd_ready=0 and dir_up=1 after edge 0; cur_floor=1 and arrive pulse at edge 4; door_open high for 3 cycles; cmd_ready=1 after edge 7.
- From floor 0, floor 2 accepted at edge 0: cur_floor=1 at edge 4 with no arrive; cur_floor=2 and the single arrive pulse at edge 8; floor_led=100; door_open for 3 cycles.
- From floor 2, floor 2 accepted: arrive immediately, moving never 1, door_open for 3 cycles; then floor 0 command gives dir_up=0, steps 2→1→0 every 4 cycles.
- reset driven low 2 cycles into a 0→2 move: all outputs return to reset values before the next edge; after release, floor 1 command takes 4 cycles from floor 0.
- cmd_floor=3 with cmd_valid in IDLE: with ELEV_CMD_CHECK_EN, fault=1 sticky, no motion, next floor-1 command still serviced; without it, fault=0 and no motion.

Source files
------------

// File: rtl/elevator_car_drive.sv
// Car-side motion sequencer: accepts a target floor, times travel and door dwell.
// Optional build macro ELEV_CMD_CHECK_EN makes floor-3 commands set a sticky fault.
module elevator_car_drive #(
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_floor,
  output logic       cmd_ready,
  output logic [1:0] cur_floor,
  output logic [2:0] floor_led,
  output logic       moving,
  output logic       dir_up,
  output logic       arrive,
  output logic       door_open,
  output logic       fault
);

  localparam int MAX_C =
    (TRAVEL_CYCLES > DOOR_CYCLES) ?
    TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] TRAVEL_LD =
    CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LD =
    CW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    target, target_n;
  logic [1:0]    floor_n;
  logic [1:0]    step_floor;
  logic          dir_n;
  logic          arrive_n;
  logic          fault_set;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    target_n   = target;
    floor_n    = cur_floor;
    dir_n      = dir_up;
    arrive_n   = 1'b0;
    fault_set  = 1'b0;
    step_floor = dir_up ?
                 cur_floor + 2'd1 :
                 cur_floor - 2'd1;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          unique case (1'b1)
            (cmd_floor == 2'd3): begin
              fault_set = 1'b1;
            end
            (cmd_floor == cur_floor): begin
              state_n  = DOOR;
              arrive_n = 1'b1;
              cnt_n    = DOOR_LD;
            end
            default: begin
              state_n  = MOVE;
              target_n = cmd_floor;
              dir_n    = (cmd_floor > cur_floor);
              cnt_n    = TRAVEL_LD;
            end
          endcase
        end
      end
      MOVE: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          floor_n = step_floor;
          if (step_floor == target) begin
            state_n  = DOOR;
            arrive_n = 1'b1;
            cnt_n    = DOOR_LD;
          end else begin
            cnt_n = TRAVEL_LD;
          end
        end
      end
      DOOR: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state view so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      target    <= 2'd0;
      cur_floor <= 2'd0;
      floor_led <= 3'b001;
      dir_up    <= 1'b0;
      arrive    <= 1'b0;
      cmd_ready <= 1'b1;
      moving    <= 1'b0;
      door_open <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      target    <= target_n;
      cur_floor <= floor_n;
      floor_led <= 3'b001 << floor_n;
      dir_up    <= dir_n;
      arrive    <= arrive_n;
      cmd_ready <= (state_n == IDLE);
      moving    <= (state_n == MOVE);
      door_open <= (state_n == DOOR);
    end
  end

`ifdef ELEV_CMD_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  logic unused_fault_set;

  assign unused_fault_set = fault_set;
  assign fault            = 1'b0;
`endif

endmodule

// File: tb/tb_elevator_car_drive.sv
// Directed bench for elevator_car_drive with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
// Expected values are hand-derived per cycle; sampled 1 time unit after each edge.
module tb_elevator_car_drive;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_floor;
  logic       cmd_ready;
  logic [1:0] cur_floor;
  logic [2:0] floor_led;
  logic       moving;
  logic       dir_up;
  logic       arrive;
  logic       door_open;
  logic       fault;

  int ncmp = 0;
  int nerr = 0;

`ifdef ELEV_CMD_CHECK_EN
  localparam logic FAULT_EXP = 1'b1;
`else
  localparam logic FAULT_EXP = 1'b0;
`endif

  elevator_car_drive #(
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_floor(cmd_floor),
    .cmd_ready(cmd_ready),
    .cur_floor(cur_floor),
    .floor_led(floor_led),
    .moving   (moving),
    .dir_up   (dir_up),
    .arrive   (arrive),
    .door_open(door_open),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  // One packed comparison: {floor, led, arrive, moving, door, ready}
  task automatic cyc(input string tag,
                     input logic [1:0] f,
                     input logic a,
                     input logic m,
                     input logic d,
                     input logic r);
    logic [2:0] led;
    led = 3'b001 << f;
    chk(tag,
        {23'd0, cur_floor, floor_led,
         arrive, moving, door_open, cmd_ready},
        {23'd0, f, led, a, m, d, r});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] fl);
    cmd_valid = 1'b1;
    cmd_floor = fl;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called just after the accept edge of a move command.
  task automatic trip(input string tag,
                      input logic [1:0] from,
                      input int hops,
                      input logic up);
    logic [1:0] f;
    f = from;
    cyc({tag, "_acc"}, f, 0, 1, 0, 0);
    chk({tag, "_dir"}, {31'd0, dir_up}, {31'd0, up});
    for (int h = 0; h < hops; h++) begin
      repeat (3) begin
        tick();
        cyc({tag, "_trv"}, f, 0, 1, 0, 0);
      end
      tick();
      f = up ? f + 2'd1 : f - 2'd1;
      if (h == hops - 1)
        cyc({tag, "_arr"}, f, 1, 0, 1, 0);
      else
        cyc({tag, "_mid"}, f, 0, 1, 0, 0);
    end
    tick();
    cyc({tag, "_dr1"}, f, 0, 0, 1, 0);
    tick();
    cyc({tag, "_dr2"}, f, 0, 0, 1, 0);
    tick();
    cyc({tag, "_idl"}, f, 0, 0, 0, 1);
  endtask

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_floor = 2'd0;
    repeat (2) tick();
    cyc("rst_low", 0, 0, 0, 0, 1);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_dir", {31'd0, dir_up}, 32'd0);
    #2 reset = 1'b1;
    tick();
    cyc("rst_rel", 0, 0, 0, 0, 1);

    send(2'd1);
    trip("up1", 2'd0, 1, 1'b1);

    send(2'd0);
    trip("dn1", 2'd1, 1, 1'b0);

    send(2'd2);
    trip("up2", 2'd0, 2, 1'b1);

    send(2'd2);
    cyc("same_acc", 2, 1, 0, 1, 0);
    chk("same_dir", {31'd0, dir_up}, 32'd1);
    tick();
    cyc("same_dr1", 2, 0, 0, 1, 0);
    tick();
    cyc("same_dr2", 2, 0, 0, 1, 0);
    tick();
    cyc("same_idl", 2, 0, 0, 0, 1);

    send(2'd0);
    trip("dn2", 2'd2, 2, 1'b0);

    send(2'd2);
    cyc("rm_acc", 0, 0, 1, 0, 0);
    cmd_valid = 1'b1;
    cmd_floor = 2'd1;
    tick();
    cmd_valid = 1'b0;
    cyc("rm_ign", 0, 0, 1, 0, 0);
    #3 reset = 1'b0;
    #1;
    cyc("rm_async", 0, 0, 0, 0, 1);
    chk("rm_dir", {31'd0, dir_up}, 32'd0);
    tick();
    #3 reset = 1'b1;
    tick();
    cyc("rm_idle", 0, 0, 0, 0, 1);
    send(2'd1);
    trip("post", 2'd0, 1, 1'b1);

    send(2'd3);
    cyc("bad_acc", 1, 0, 0, 0, 1);
    chk("bad_flt", {31'd0, fault}, {31'd0, FAULT_EXP});
    tick();
    cyc("bad_hold", 1, 0, 0, 0, 1);
    chk("bad_stk", {31'd0, fault}, {31'd0, FAULT_EXP});
    send(2'd2);
    trip("aft", 2'd1, 1, 1'b1);
    chk("aft_flt", {31'd0, fault}, {31'd0, FAULT_EXP});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
